// File: rtl/alu_resp_if.sv
// Command/response bundle for alu_resp.
// master drives commands and consumes responses; slave is the responder.
interface alu_resp_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             ovf_clr;
    logic             ovf_sticky;

    modport master (
        output cmd_valid, opcode, operand_a, operand_b,
        output rsp_ready, ovf_clr,
        input  cmd_ready, rsp_valid, result, overflow, ovf_sticky
    );

    modport slave (
        input  cmd_valid, opcode, operand_a, operand_b,
        input  rsp_ready, ovf_clr,
        output cmd_ready, rsp_valid, result, overflow, ovf_sticky
    );
endinterface

// File: rtl/alu_resp.sv
// Handshaked registered ALU responder: IDLE accept, EXEC compute, RESP hold.
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_resp #(
    parameter int WIDTH = 4
) (
    input logic      clk,
    input logic      rst,
    alu_resp_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             ovf_q;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are frozen at acceptance so later bus changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (state_q == IDLE && bus.cmd_valid) begin
            op_q <= bus.opcode;
            a_q  <= bus.operand_a;
            b_q  <= bus.operand_b;
        end
    end

    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op_q)
            3'd0: begin
                alu_res = sum;
                alu_ovf = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            3'd1: begin
                alu_res = diff;
                alu_ovf = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            3'd5: alu_res = ~a_q;
            3'd6: begin
                alu_res = {a_q[MSB-1:0], 1'b0};
                alu_ovf = a_q[MSB];
            end
            3'd7: begin
                alu_res = {1'b0, a_q[MSB:1]};
                alu_ovf = a_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else if (state_q == EXEC) begin
            res_q <= alu_res;
            ovf_q <= alu_ovf;
        end
    end

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q;

    // A new overflow outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (state_q == EXEC && alu_ovf) begin
            sticky_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.ovf_sticky = sticky_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.ovf_clr;
    assign bus.ovf_sticky = 1'b0;
`endif

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.result    = res_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_resp.sv
// Directed scoreboard bench for alu_resp (WIDTH=4).
// Sticky expectations follow ALU_STICKY_OVF_EN.
module tb_alu_resp;
    localparam int W = 4;
`ifdef ALU_STICKY_OVF_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [W:0] sb[$];

    alu_resp_if #(.WIDTH(W)) bus ();

    alu_resp #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: signed overflow judged by range of the exact integer result.
    function automatic logic [W:0] model(input logic [2:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        int         full;
        logic [W-1:0] r;
        logic       o;
        full = 0;
        r    = '0;
        o    = 1'b0;
        case (op)
            3'd0: begin
                full = int'($signed(a)) + int'($signed(b));
                r    = full[W-1:0];
                o    = (full > 2**(W-1) - 1) || (full < -(2**(W-1)));
            end
            3'd1: begin
                full = int'($signed(a)) - int'($signed(b));
                r    = full[W-1:0];
                o    = (full > 2**(W-1) - 1) || (full < -(2**(W-1)));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin
                r = a << 1;
                o = a[W-1];
            end
            default: begin
                r = a >> 1;
                o = a[0];
            end
        endcase
        return {o, r};
    endfunction

    task automatic chk(input string tag, input logic [W:0] obs,
                       input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("ready_before_cmd", bus.cmd_ready, 1);
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold,
                        input bit clr_exec);
        logic [W:0] e;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.opcode    = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.rsp_ready = (hold == 0);
        sb.push_back(model(op, a, b));
        tick();
        bus.cmd_valid = 1'b0;
        bus.opcode    = ~op;
        bus.operand_a = ~a;
        bus.operand_b = a ^ b ^ 4'h5;
        bus.ovf_clr   = clr_exec;
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        chk("exec_cmd_ready", bus.cmd_ready, 0);
        tick();
        bus.ovf_clr = 1'b0;
        chk("latency_rsp_valid", bus.rsp_valid, 1);
        e = sb.pop_front();
        chk("resp_data", {bus.overflow, bus.result}, e);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_data", {bus.overflow, bus.result}, e);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("handoff_cmd_ready", bus.cmd_ready, 1);
        chk("handoff_rsp_valid", bus.rsp_valid, 0);
        chk("idle_data_held", {bus.overflow, bus.result}, e);
    endtask

    initial begin
        int last_acc;
        int n;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.opcode    = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.rsp_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_data", {bus.overflow, bus.result}, 0);
        chk("rst_sticky", bus.ovf_sticky, 0);
        rst = 1'b0;
        tick();

        for (int op = 0; op < 8; op++) begin
            send(3'(op), 4'd8, 4'd7, 0, 1'b0);
        end
        chk("sweep_sticky", bus.ovf_sticky, STK);

        send(3'd0, 4'd7, 4'd1, 5, 1'b0);

        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.opcode    = 3'd1;
        bus.operand_a = 4'd8;
        bus.operand_b = 4'd7;
        bus.rsp_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("pre_rst_exec", bus.rsp_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        chk("mid_rst_data", {bus.overflow, bus.result}, 0);
        chk("mid_rst_sticky", bus.ovf_sticky, 0);
        tick();
        chk("mid_rst_no_rsp1", bus.rsp_valid, 0);
        tick();
        chk("mid_rst_no_rsp2", bus.rsp_valid, 0);

        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        tick();
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("rst_ignores_cmd", bus.cmd_ready, 1);
        tick();
        chk("rst_ignores_cmd2", bus.cmd_ready, 1);

        last_acc      = -1;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.opcode    = 3'(cyc);
            bus.operand_a = 4'(cyc * 3 + 1);
            bus.operand_b = 4'(cyc * 5 + 2);
            chk("no_ready_with_valid", bus.cmd_ready & bus.rsp_valid, 0);
            if (bus.rsp_valid === 1'b1) begin
                chk("stream_data", {bus.overflow, bus.result},
                    sb.pop_front());
            end
            if (bus.cmd_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    chk("accept_spacing", 1'(cyc - last_acc >= 3), 1);
                end
                last_acc = cyc;
                sb.push_back(model(bus.opcode, bus.operand_a,
                                   bus.operand_b));
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 4) begin
            if (bus.rsp_valid === 1'b1) begin
                chk("drain_data", {bus.overflow, bus.result},
                    sb.pop_front());
            end
            tick();
            n++;
        end
        chk("drain_empty", 5'(sb.size()), 0);

        wait_ready();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("sticky_cleared", bus.ovf_sticky, 0);
        send(3'd6, 4'd8, 4'd0, 0, 1'b0);
        chk("sticky_after_shl", bus.ovf_sticky, STK);
        send(3'd2, 4'd3, 4'd5, 0, 1'b0);
        chk("sticky_after_and", bus.ovf_sticky, STK);
        send(3'd1, 4'd8, 4'd7, 0, 1'b1);
        chk("sticky_set_wins", bus.ovf_sticky, STK);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("sticky_clr_alone", bus.ovf_sticky, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
